gate_exerciser: RTL and testbench



---
 rtl/gate_ex_pkg.sv | 25 ++
 rtl/gate_exerciser_if.sv | 22 ++
 rtl/gate_exerciser_hold_timer.sv | 29 ++
 rtl/gate_exerciser.sv | 133 +++++++++++++
 tb/tb_gate_exerciser.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_ex_pkg.sv
// Shared types and constants for the gate exerciser: FSM states, vector order, default truth table.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package gate_ex_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_VEC = 4;

  // Sweep order, one 2-bit {a,b} vector per slot, slot 0 in the low bits.
  localparam logic [2*NUM_VEC-1:0] VEC_ORDER = {2'b11, 2'b10, 2'b01, 2'b00};

  // Expected c per {a,b}; 4'b1010 is a&b | b&~a, i.e. c follows b.
  localparam logic [NUM_VEC-1:0] DEFAULT_TRUTH = 4'b1010;

  // Vector driven in sweep slot idx.
  function automatic logic [1:0] vec_at(input logic [1:0] idx);
    return VEC_ORDER[{idx, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/gate_exerciser_if.sv
// Pin-level a/b -> c connection between the exerciser and a 2-input gate under test.
// Latency: none; the gate path is purely combinational.
// Backpressure: none; the gate always answers in the same cycle.
interface gate_exerciser_if;
  logic a_out;
  logic b_out;
  logic c_in;

  // Driving/checking side (the exerciser).
  modport master (
    output a_out,
    output b_out,
    input  c_in
  );

  // Gate side.
  modport slave (
    input  a_out,
    input  b_out,
    output c_in
  );
endinterface

// File: rtl/gate_exerciser_hold_timer.sv
// Counts the cycles a vector has been held and flags the last one.
// Latency: expire is combinational from the count, high in cycle HOLD_CYCLES-1 of each hold.
// Backpressure: none; counting pauses while en is low, clr restarts from zero.
module hold_timer #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign expire = en && (cnt == CW'(HOLD_CYCLES - 1));

  // Hold counter: wraps to zero on its own after the last cycle so the next vector starts clean.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= expire ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/gate_exerciser.sv
// Sweeps {a,b} = 00,01,10,11 into a 2-input gate, samples c at the end of each hold, records mismatches.
// Latency: done reads 1 after edge N + 4*HOLD_CYCLES*LOOPS + 1 when start is seen at edge N.
// Backpressure: none; start is ignored while a sweep is in progress.
module gate_exerciser
  import gate_ex_pkg::*;
#(
  parameter int                 HOLD_CYCLES = 4,
  parameter int                 LOOPS       = 1,
  parameter logic [NUM_VEC-1:0] TRUTH       = DEFAULT_TRUTH,
  parameter int                 CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  gate_exerciser_if.master        gate,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [CNT_W-1:0]        err_count,
  output logic [NUM_VEC-1:0]      err_vec
);

  localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;

  state_t        state;
  logic [1:0]    idx;
  logic [LW-1:0] loop;
  logic          a_q;
  logic          b_q;

  logic          launch;
  logic          timer_en;
  logic          expire;
  logic [1:0]    cur_vec;
  logic          mismatch;
  logic          last_vec;
  logic          last_loop;
  logic          cnt_full;

  assign gate.a_out = a_q;
  assign gate.b_out = b_q;

  // A new run may only begin from a quiescent state.
  assign launch   = start && (state != DRIVE);
  assign timer_en = (state == DRIVE);

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (launch),
    .en     (timer_en),
    .expire (expire)
  );

  // Checker inputs: gate output versus the truth-table entry for the vector on the pins now.
  assign cur_vec   = vec_at(idx);
  assign mismatch  = (gate.c_in != TRUTH[cur_vec]);
  assign last_vec  = (idx == 2'(NUM_VEC - 1));
  assign last_loop = (loop == LW'(LOOPS - 1));
  assign cnt_full  = (err_count == {CNT_W{1'b1}});

  // Sequencer, vector/loop counters and mismatch recording in one registered FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      loop      <= '0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      err_vec   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= DRIVE;
            idx          <= '0;
            loop         <= '0;
            {a_q, b_q}   <= vec_at(2'd0);
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            err_vec      <= '0;
          end else if (state == DONE) begin
            // done/pass follow one cycle after entering DONE so that pass
            // is derived from the already-settled final err_count.
            done <= 1'b1;
            pass <= (err_count == '0);
          end
        end

        DRIVE: begin
          if (expire) begin
            if (mismatch) begin
              err_vec[cur_vec] <= 1'b1;
              if (!cnt_full) begin
                err_count <= err_count + CNT_W'(1);
              end
            end
            if (last_vec) begin
              if (last_loop) begin
                state      <= DONE;
                busy       <= 1'b0;
                {a_q, b_q} <= 2'b00;
              end else begin
                loop       <= loop + LW'(1);
                idx        <= '0;
                {a_q, b_q} <= vec_at(2'd0);
              end
            end else begin
              idx        <= idx + 2'd1;
              {a_q, b_q} <= vec_at(idx + 2'd1);
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Directed bench for gate_exerciser: several parameterisations driving behavioural gate models.
// Latency: checks each cycle against hand-derived sweep timing.
// Backpressure: n/a.
module tb_gate_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic st0, st3, st1;
  int   mode0;

  int checks = 0;
  int errors = 0;

  // 0: a&b | b&~a, 1: a&b, other: constant 1
  function automatic logic gate_fn(input int m, input logic a, input logic b);
    case (m)
      0:       return (a & b) | (b & ~a);
      1:       return a & b;
      default: return 1'b1;
    endcase
  endfunction

  gate_exerciser_if gif0 ();
  gate_exerciser_if gif3 ();
  gate_exerciser_if gif3s ();
  gate_exerciser_if gif1 ();

  assign gif0.c_in  = gate_fn(mode0, gif0.a_out, gif0.b_out);
  assign gif3.c_in  = gate_fn(2, gif3.a_out, gif3.b_out);
  assign gif3s.c_in = gate_fn(2, gif3s.a_out, gif3s.b_out);
  assign gif1.c_in  = gate_fn(0, gif1.a_out, gif1.b_out);

  logic busy0, done0, pass0;  logic [7:0] cnt0;  logic [3:0] ev0;
  logic busy3, done3, pass3;  logic [2:0] cnt3;  logic [3:0] ev3;
  logic busy3s, done3s, pass3s; logic [1:0] cnt3s; logic [3:0] ev3s;
  logic busy1, done1, pass1;  logic [7:0] cnt1;  logic [3:0] ev1;

  gate_exerciser u0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .gate(gif0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(cnt0), .err_vec(ev0)
  );

  gate_exerciser #(.LOOPS(3), .CNT_W(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(st3), .gate(gif3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(cnt3), .err_vec(ev3)
  );

  gate_exerciser #(.LOOPS(3), .CNT_W(2)) u3s (
    .clk(clk), .rst_n(rst_n), .start(st3), .gate(gif3s),
    .busy(busy3s), .done(done3s), .pass(pass3s), .err_count(cnt3s), .err_vec(ev3s)
  );

  gate_exerciser #(.HOLD_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .gate(gif1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(cnt1), .err_vec(ev1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start u0, check pins every cycle of the 16-cycle sweep, then done/pass/results.
  // glitch_at >= 0 raises start again during that sweep cycle (must be ignored).
  task automatic do_run(input int glitch_at, input logic [3:0] exp_vec,
                        input logic [7:0] exp_cnt, input logic exp_pass, input string tag);
    logic [1:0] e_ab;
    st0 = 1'b1;
    step();
    st0 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      e_ab = 2'(k / 4);
      checks++;
      if ({gif0.a_out, gif0.b_out, busy0, done0} !== {e_ab, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL %s sweep cyc %0d: {a,b,busy,done}=%b want %b", tag, k,
                 {gif0.a_out, gif0.b_out, busy0, done0}, {e_ab, 1'b1, 1'b0});
      end
      st0 = (k == glitch_at);
      step();
    end
    st0 = 1'b0;
    checks++;
    if ({gif0.a_out, gif0.b_out, busy0, done0} !== 4'b0000) begin
      errors++;
      $display("FAIL %s post-sweep cyc: {a,b,busy,done}=%b want 0000", tag,
               {gif0.a_out, gif0.b_out, busy0, done0});
    end
    step();
    checks++;
    if ({done0, pass0, cnt0, ev0} !== {1'b1, exp_pass, exp_cnt, exp_vec}) begin
      errors++;
      $display("FAIL %s result: done=%b pass=%b cnt=%0d vec=%b want done=1 pass=%b cnt=%0d vec=%b",
               tag, done0, pass0, cnt0, ev0, exp_pass, exp_cnt, exp_vec);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; st0 = 1'b0; st3 = 1'b0; st1 = 1'b0; mode0 = 0;
    step(); step();
    checks++;
    if ({gif0.a_out, gif0.b_out, busy0, done0, pass0, cnt0, ev0} !== '0) begin
      errors++; $display("FAIL reset u0: outputs not zero (busy=%b done=%b cnt=%0d vec=%b)", busy0, done0, cnt0, ev0);
    end
    checks++;
    if ({gif3.a_out, gif3.b_out, busy3, done3, pass3, cnt3, ev3} !== '0) begin
      errors++; $display("FAIL reset u3: outputs not zero (busy=%b done=%b cnt=%0d vec=%b)", busy3, done3, cnt3, ev3);
    end
    checks++;
    if ({gif1.a_out, gif1.b_out, busy1, done1, pass1, cnt1, ev1} !== '0) begin
      errors++; $display("FAIL reset u1: outputs not zero (busy=%b done=%b cnt=%0d vec=%b)", busy1, done1, cnt1, ev1);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_sweep();
    mode0 = 0;
    do_run(-1, 4'b0000, 8'd0, 1'b1, "sweep");
  endtask

  task automatic test_mismatch();
    mode0 = 1;
    do_run(-1, 4'b0010, 8'd1, 1'b0, "and_gate");
  endtask

  // u0 sits in DONE with errors recorded; a start must clear them on that edge.
  task automatic test_restart_in_done();
    int cyc;
    mode0 = 0;
    st0 = 1'b1;
    step();
    st0 = 1'b0;
    checks++;
    if ({cnt0, ev0, done0, busy0, gif0.a_out, gif0.b_out} !== {8'd0, 4'b0000, 1'b0, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL restart_clear: cnt=%0d vec=%b done=%b busy=%b ab=%b%b want 0 0000 0 1 00",
               cnt0, ev0, done0, busy0, gif0.a_out, gif0.b_out);
    end
    cyc = 0;
    while (!done0 && cyc < 40) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc != 17 || pass0 !== 1'b1) begin
      errors++;
      $display("FAIL restart_run: done after %0d edges pass=%b want 17 and pass=1", cyc, pass0);
    end
  endtask

  task automatic test_start_ignored();
    mode0 = 0;
    do_run(6, 4'b0000, 8'd0, 1'b1, "start_in_drive");
  endtask

  task automatic test_reset_mid_sweep();
    mode0 = 0;
    st0 = 1'b1;
    step();
    st0 = 1'b0;
    repeat (9) step();
    checks++;
    if ({gif0.a_out, gif0.b_out} !== 2'b10) begin
      errors++; $display("FAIL midreset_pre: ab=%b%b want 10", gif0.a_out, gif0.b_out);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if ({gif0.a_out, gif0.b_out, busy0, done0, pass0, cnt0, ev0} !== '0) begin
      errors++;
      $display("FAIL midreset_state: ab=%b%b busy=%b done=%b pass=%b cnt=%0d vec=%b want all 0",
               gif0.a_out, gif0.b_out, busy0, done0, pass0, cnt0, ev0);
    end
    rst_n = 1'b1;
    step();
    do_run(-1, 4'b0000, 8'd0, 1'b1, "after_reset");
  endtask

  task automatic test_saturation();
    int cyc;
    st3 = 1'b1;
    step();
    st3 = 1'b0;
    cyc = 0;
    while (!done3 && cyc < 100) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc != 49) begin
      errors++; $display("FAIL loops3_latency: done after %0d edges want 49", cyc);
    end
    checks++;
    if ({cnt3, ev3, pass3} !== {3'd6, 4'b0101, 1'b0}) begin
      errors++; $display("FAIL loops3_result: cnt=%0d vec=%b pass=%b want 6 0101 0", cnt3, ev3, pass3);
    end
    checks++;
    if ({cnt3s, ev3s, done3s} !== {2'd3, 4'b0101, 1'b1}) begin
      errors++; $display("FAIL saturate: cnt=%0d vec=%b done=%b want 3 0101 1", cnt3s, ev3s, done3s);
    end
  endtask

  task automatic test_hold_one();
    logic [3:0] exp_tab [6];
    exp_tab[0] = 4'b0010; exp_tab[1] = 4'b0110; exp_tab[2] = 4'b1010;
    exp_tab[3] = 4'b1110; exp_tab[4] = 4'b0000; exp_tab[5] = 4'b0001;
    st1 = 1'b1;
    step();
    st1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({gif1.a_out, gif1.b_out, busy1, done1} !== exp_tab[k]) begin
        errors++;
        $display("FAIL hold1 cyc %0d: {a,b,busy,done}=%b want %b", k,
                 {gif1.a_out, gif1.b_out, busy1, done1}, exp_tab[k]);
      end
      if (k < 5) step();
    end
    checks++;
    if ({pass1, cnt1, ev1} !== {1'b1, 8'd0, 4'b0000}) begin
      errors++; $display("FAIL hold1_result: pass=%b cnt=%0d vec=%b want 1 0 0000", pass1, cnt1, ev1);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_mismatch();
    test_restart_in_done();
    test_start_ignored();
    test_reset_mid_sweep();
    test_saturation();
    test_hold_one();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
